// File: rtl/i2c_codec_responder.sv
// i2c_codec_responder: write-only I2C target modelling the WM8731 control port.
// Accepts <dev_addr+W> <reg_idx[6:0],data[8]> <data[7:0]>, ACKs each byte and
// stores the 9-bit value into a 16-entry register file.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | bus idle or released, waiting for START
// S_ADDR   | shifting in device address + R/W bit
// S_ACK_A  | pulling SDA low for the address ACK
// S_BYTE1  | shifting in {reg_idx[6:0], data[8]}
// S_ACK_1  | pulling SDA low for the first data ACK
// S_BYTE2  | shifting in data[7:0]; commit on its last bit
// S_ACK_2  | pulling SDA low for the second data ACK
// S_IGNORE | not addressed / transaction done, wait for START or STOP
module i2c_codec_responder #(
  parameter logic [6:0] DEV_ADDR   = 7'h1A,
  parameter int         FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       busy,
  output logic       wr_valid,
  output logic [6:0] wr_addr,
  output logic [8:0] wr_data,
  input  logic [3:0] rd_addr,
  output logic [8:0] rd_data,
  output logic [7:0] nack_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ACK_A, S_BYTE1, S_ACK_1, S_BYTE2, S_ACK_2, S_IGNORE
  } state_t;

  localparam logic [3:0] FCNT_INIT = 4'(FILTER_LEN - 1);

  // index 0 = SCL, index 1 = SDA
  logic [1:0] sync1_q, sync2_q, filt_q, filt_dly_q;
  logic [3:0] fcnt_q [2];

  logic scl_f, sda_f, scl_p, sda_p;
  logic scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] byte_in;

  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [6:0] idx_q, idx_d;
  logic       d8_q, d8_d;
  logic       busy_q, busy_d;
  logic       wr_valid_q, wr_valid_d;
  logic [6:0] wr_addr_q, wr_addr_d;
  logic [8:0] wr_data_q, wr_data_d;
  logic [7:0] nack_q, nack_d;
  logic [8:0] regs_q [16];
  logic [8:0] regs_d [16];

  // Synchronize both pins, then only follow a new level once it has been
  // stable for FILTER_LEN samples (down-counter hits terminal count 0).
  // Both pins share one path so their relative ordering is preserved.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      filt_q     <= '1;
      filt_dly_q <= '1;
      fcnt_q[0]  <= FCNT_INIT;
      fcnt_q[1]  <= FCNT_INIT;
    end else begin
      sync1_q    <= {sda_i, scl_i};
      sync2_q    <= sync1_q;
      filt_dly_q <= filt_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          fcnt_q[i] <= FCNT_INIT;
        end else if (fcnt_q[i] == 4'd0) begin
          filt_q[i] <= sync2_q[i];
          fcnt_q[i] <= FCNT_INIT;
        end else begin
          fcnt_q[i] <= fcnt_q[i] - 4'd1;
        end
      end
    end
  end

  assign scl_f     = filt_q[0];
  assign sda_f     = filt_q[1];
  assign scl_p     = filt_dly_q[0];
  assign sda_p     = filt_dly_q[1];
  assign scl_rise  = scl_f & ~scl_p;
  assign scl_fall  = ~scl_f & scl_p;
  assign start_det = scl_f & scl_p & sda_p & ~sda_f;
  assign stop_det  = scl_f & scl_p & ~sda_p & sda_f;
  assign byte_in   = {shift_q[6:0], sda_f};

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      idx_q      <= '0;
      d8_q       <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      nack_q     <= '0;
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      d8_q       <= d8_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      nack_q     <= nack_d;
      for (int i = 0; i < 16; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Next-state: START/STOP first, then bit shifting and ACK sequencing.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    d8_d       = d8_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    nack_d     = nack_q;
    for (int i = 0; i < 16; i++) regs_d[i] = regs_q[i];

    if (start_det) begin
      state_d   = S_ADDR;
      bit_cnt_d = '0;
      busy_d    = 1'b1;
    end else if (stop_det) begin
      state_d   = S_IDLE;
      bit_cnt_d = '0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        S_ADDR, S_BYTE1, S_BYTE2: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            // last bit of the value byte: commit the write
            if (state_q == S_BYTE2 && bit_cnt_q == 4'd7) begin
              wr_addr_d  = idx_q;
              wr_data_d  = {d8_q, byte_in};
              wr_valid_d = 1'b1;
              if (idx_q == 7'h0F) begin
                for (int i = 0; i < 16; i++) regs_d[i] = '0;
              end else if (idx_q < 7'h0F) begin
                regs_d[idx_q[3:0]] = {d8_q, byte_in};
              end
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            // SCL low after the 8th bit: ACK slot begins
            bit_cnt_d = '0;
            case (state_q)
              S_ADDR: begin
                if (shift_q[7:1] == DEV_ADDR && !shift_q[0]) begin
                  state_d = S_ACK_A;
                end else begin
                  state_d = S_IGNORE;
                  if (nack_q != 8'hFF) nack_d = nack_q + 8'd1;
                end
              end
              S_BYTE1: begin
                idx_d   = shift_q[7:1];
                d8_d    = shift_q[0];
                state_d = S_ACK_1;
              end
              default: state_d = S_ACK_2;
            endcase
          end
        end
        S_ACK_A: if (scl_fall) state_d = S_BYTE1;
        S_ACK_1: if (scl_fall) state_d = S_BYTE2;
        S_ACK_2: if (scl_fall) state_d = S_IGNORE;
        default: ;
      endcase
    end
  end

  // Outputs: SDA is pulled only in ACK states, so reset releases it at once.
  always_comb begin
    sda_oe   = (state_q == S_ACK_A) || (state_q == S_ACK_1) || (state_q == S_ACK_2);
    busy     = busy_q;
    wr_valid = wr_valid_q;
    wr_addr  = wr_addr_q;
    wr_data  = wr_data_q;
    nack_cnt = nack_q;
    rd_data  = regs_q[rd_addr];
  end

endmodule

// File: doc/i2c_codec_responder.md
# i2c_codec_responder

I2C target (responder) that models the WM8731 control port: accepts 3-byte write transactions (device address, then a 7-bit register index with a 9-bit value), ACKs them on the bus and stores the values in a 16-entry register file. It sits on the board-side I2C bus opposite the audio configuration master. It serves as a bring-up/loopback target in FPGA and as the reference responder in simulation benches.

## Interface
- `DEV_ADDR`, 7'h1A: 7-bit target address answered.
- `FILTER_LEN`, 3: consecutive equal synchronized samples required before a filtered SCL/SDA level changes (range 1..15).
- `clk`  in  1  system clock; must be ≥ 20× SCL frequency.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `scl_i`  in  1  raw I2C clock pin (asynchronous).
- `sda_i`  in  1  raw I2C data pin (asynchronous).
- `sda_oe`  out  1  1 = pull SDA low (open-drain); 0 = release.
- `busy`  out  1  high from detected START until detected STOP.
- `wr_valid`  out  1  one-cycle pulse per completed write.
- `wr_addr`  out  7  register index of last completed write.
- `wr_data`  out  9  value of last completed write.
- `rd_addr`  in  4  register file read index.
- `rd_data`  out  9  combinational read of `regs[rd_addr]`.
- `nack_cnt`  out  8  count of address bytes NACKed, saturating at 255.

## Operation
- Front end: 2-FF synchronizer per pin, then glitch filter (`FILTER_LEN`); all decoding uses filtered `scl_f`/`sda_f` and their 1-cycle-delayed copies.
- START: `sda_f` falls while `scl_f` high. STOP: `sda_f` rises while `scl_f` high. Data bits are sampled on `scl_f` rising, MSB first.
- States: IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, IGNORE.
- START (including repeated START) from any state -> ADDR with bit counter cleared and `sda_oe` released. STOP from any state -> IDLE, `sda_oe` released. Both take priority over bit sampling in the same cycle.
- ADDR: shift 8 bits. If `[7:1]==DEV_ADDR` and `[0]==0` -> ACK_A. Otherwise (wrong address or read request) -> IGNORE, no ACK, `nack_cnt` +1.
- ACK_x: `sda_oe`=1 from the `scl_f` falling edge after the 8th bit until the `scl_f` falling edge after the 9th clock. Then ACK_A->BYTE1, ACK_1->BYTE2, ACK_2->IGNORE.
- BYTE1 latches `{reg_idx[6:0], data[8]}`. BYTE2 latches `data[7:0]`.
- Commit occurs on the `scl_f` rising edge sampling bit 0 of BYTE2:
  - `wr_addr`/`wr_data` are loaded.
  - `wr_valid`=1 on the next cycle for exactly one cycle.
  - reg_idx 0x00–0x0E: `regs[idx] <= data`.
  - reg_idx 0x0F (reset command): all 16 regs cleared to 0.
  - reg_idx ≥ 0x10: ACKed and pulsed but not stored.
- IGNORE: `sda_oe` stays 0. Any extra bytes after ACK_2 are not ACKed. Wait for START/STOP.
- A transaction aborted by STOP or repeated START before commit produces no write and no pulse.

## Timing
- Reset values: `sda_oe`=0, `busy`=0, `wr_valid`=0, `wr_addr`=0, `wr_data`=0, `nack_cnt`=0, all regs 0, state IDLE. Synchronizer and filter outputs reset to 1 (idle bus).
- Pin-to-filtered latency: 2 + `FILTER_LEN` clk cycles, fixed and identical for both pins, so SCL/SDA ordering is preserved.
- `sda_oe` changes 1 cycle after the filtered `scl_f` falling edge that triggers it. SDA is therefore stable well before the next SCL rise at ≥ 20× oversampling.
- `busy` rises/falls 1 cycle after START/STOP detection.
- `rd_data` is combinational from `regs`; a write is visible the cycle `wr_valid` is high.
- Asserting `reset_n` mid-transaction forces IDLE and releases SDA immediately (asynchronously). The bus master sees a missing ACK.
- Pulses on either pin shorter than `FILTER_LEN` cycles are ignored entirely.

## Test plan
- Write 0x34, 0x04, 0x7F (reg 0x02, data 0x07F) at 100 kHz SCL, clk 50 MHz -> three ACKs; one `wr_valid` pulse with `wr_addr`=0x02, `wr_data`=0x07F; `rd_addr`=2 gives 0x07F.
- Write reg 0x04 data 0x116 (bytes 0x34, 0x09, 0x16), then reset command (0x34, 0x1E, 0x00) -> after second pulse `wr_addr`=0x0F and `rd_data` for 2 and 4 is 0.
- Address byte 0x36 (addr 0x1B), then 0x35 (read) -> SDA never pulled low, no `wr_valid`, `nack_cnt`=2.
- Repeated START after 4 bits of BYTE2, then full valid write to reg 0x07 data 0x001 -> single pulse for reg 0x07 only. STOP after BYTE1 -> no pulse, `busy` 0.
- 2-cycle glitch on SCL during BYTE1 with `FILTER_LEN`=3 -> decoded byte unchanged, write commits correctly.
- `reset_n` low during ACK_1 -> `sda_oe`=0 at once, regs 0. Next full transaction is accepted normally.
